// File: rtl/ir_baud_gen_param_if.sv
// rtl/ir_baud_gen_param_if.sv - control/strobe bundle between UART FSMs and the IrDA bit-timing generator
// master = UART side driving control; slave = the timing generator.
interface ir_baud_gen_param_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             resync;
  logic [CNT_W-1:0] baud_div;
  logic             pulse_mode;
  logic             full_baud;
  logic             half_bit_sample;
  logic             pulse;
  logic             os_tick;
  logic [3:0]       os_idx;

  modport master (
    output enable, resync, baud_div, pulse_mode,
    input  full_baud, half_bit_sample, pulse, os_tick, os_idx
  );

  modport slave (
    input  enable, resync, baud_div, pulse_mode,
    output full_baud, half_bit_sample, pulse, os_tick, os_idx
  );
endinterface

// File: rtl/ir_baud_gen_param.sv
// rtl/ir_baud_gen_param.sv - IrDA SIR bit-timing generator: baud strobe, sample strobe, IR pulse window
// Define IR_OS_TICK_EN to build the 16x oversample counter (os_tick/os_idx); otherwise those outputs are tied 0.
module ir_baud_gen_param #(
  parameter int CNT_W         = 16,
  parameter int DIV_DEFAULT   = 5208,
  parameter int SAMPLE_OFS    = 60,
  parameter int PULSE_MIN_CYC = 82
) (
  input logic             clock,
  input logic             reset,
  ir_baud_gen_param_if.slave bus
);

  localparam logic [CNT_W-1:0] MIN_P     = CNT_W'(16);
  localparam logic [CNT_W-1:0] PULSE_MIN = CNT_W'(PULSE_MIN_CYC);
  localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(SAMPLE_OFS);
  localparam bit               SAMPLE_OK = (64'(SAMPLE_OFS) < (64'(1) << CNT_W));

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             mode_q, mode_d;

  logic             run;
  logic             last;
  logic             load;
  logic [CNT_W+1:0] triple;
  logic [CNT_W-1:0] pm1;
  logic [CNT_W-1:0] width_frac;
  logic [CNT_W-1:0] width_fix;
  logic [CNT_W-1:0] width;
  logic [CNT_W-1:0] start;
  logic [CNT_W-1:0] offset;
  logic             in_pulse;

  // Reset behaves like enable low so every output is gated in the same cycle.
  assign run    = bus.enable && !reset;
  assign pm1    = period_q - CNT_W'(1);
  assign last   = (count_q >= pm1);
  assign load   = run && !bus.resync && (count_q == '0);

  assign triple     = {2'b00, period_q} + {1'b0, period_q, 1'b0};
  assign width_frac = CNT_W'(triple >> 4);
  assign width_fix  = (pm1 < PULSE_MIN) ? pm1 : PULSE_MIN;
  assign width      = mode_q ? width_fix : width_frac;
  assign start      = (period_q >> 1) - (width >> 1);
  assign offset     = count_q - start;
  assign in_pulse   = (count_q >= start) && (offset < width);

  always_comb begin
    count_d  = count_q;
    period_d = period_q;
    mode_d   = mode_q;
    if (!run || bus.resync || last) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
    if (load) begin
      period_d = (bus.baud_div < MIN_P) ? MIN_P : bus.baud_div;
      mode_d   = bus.pulse_mode;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q  <= '0;
      period_q <= CNT_W'(DIV_DEFAULT);
      mode_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      period_q <= period_d;
      mode_q   <= mode_d;
    end
  end

  assign bus.full_baud       = run && !bus.resync && last;
  assign bus.half_bit_sample = run && SAMPLE_OK && (count_q == SAMPLE_AT);
  assign bus.pulse           = run && in_pulse;

`ifdef IR_OS_TICK_EN
  localparam int OS_W = CNT_W - 4;

  logic [OS_W-1:0] os_cnt_q, os_cnt_d;
  logic [3:0]      os_idx_q, os_idx_d;
  logic [OS_W-1:0] os_max;
  logic            os_hit;

  assign os_max = OS_W'(period_q >> 4) - OS_W'(1);
  assign os_hit = run && (os_cnt_q == os_max);

  // The index saturates so the last partial sixteenth of a long bit stays at 15.
  always_comb begin
    os_cnt_d = os_cnt_q;
    os_idx_d = os_idx_q;
    if (!run || bus.resync || last) begin
      os_cnt_d = '0;
      os_idx_d = '0;
    end else if (os_hit) begin
      os_cnt_d = '0;
      os_idx_d = (os_idx_q == 4'd15) ? 4'd15 : os_idx_q + 4'd1;
    end else begin
      os_cnt_d = os_cnt_q + OS_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      os_cnt_q <= '0;
      os_idx_q <= '0;
    end else begin
      os_cnt_q <= os_cnt_d;
      os_idx_q <= os_idx_d;
    end
  end

  assign bus.os_tick = os_hit;
  assign bus.os_idx  = os_idx_q;
`else
  assign bus.os_tick = 1'b0;
  assign bus.os_idx  = 4'd0;
`endif

endmodule

// File: tb/tb_ir_baud_gen_param.sv
// tb/tb_ir_baud_gen_param.sv - scoreboard bench for ir_baud_gen_param
// Events are encoded as cyc*128 + kind*16 + val (kind 0 fb, 1 sample, 2 rise, 3 fall, 4 os_tick, 5 os_idx).
module tb_ir_baud_gen_param;

  localparam int P0 = 5208;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ir_baud_gen_param_if #(.CNT_W(16)) bif ();

  ir_baud_gen_param #(
    .CNT_W(16), .DIV_DEFAULT(5208), .SAMPLE_OFS(60), .PULSE_MIN_CYC(82)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif.slave)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int       n_checks = 0;
  int       n_fail   = 0;
  longint   exp_q[$];
  longint   act_q[$];
  bit       prev_pulse;
  logic [3:0] prev_idx;
  bit       rec_os;
  int       t0;
  longint   e, a;

  function automatic longint ev(int c, int k, int v);
    return longint'(c) * 128 + longint'(k * 16 + v);
  endfunction

  task automatic go();
    @(posedge clock);
    #1;
  endtask

  task automatic scan(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (bif.full_baud) act_q.push_back(ev(cyc, 0, 0));
      if (bif.half_bit_sample) act_q.push_back(ev(cyc, 1, 0));
      if (bif.pulse && !prev_pulse) act_q.push_back(ev(cyc, 2, 0));
      if (!bif.pulse && prev_pulse) act_q.push_back(ev(cyc, 3, 0));
      prev_pulse = bif.pulse;
      if (rec_os) begin
        if (bif.os_tick) act_q.push_back(ev(cyc, 4, 0));
        if (bif.os_idx !== prev_idx) act_q.push_back(ev(cyc, 5, int'(bif.os_idx)));
        prev_idx = bif.os_idx;
      end
    end
  endtask

  task automatic start_run(input int div, input bit mode);
    go();
    bif.enable = 1'b0;
    bif.resync = 1'b0;
    go();
    bif.baud_div   = 16'(div);
    bif.pulse_mode = mode;
    bif.enable     = 1'b1;
    t0 = cyc;
    prev_pulse = 1'b0;
    prev_idx   = 4'd0;
    exp_q.delete();
    act_q.delete();
  endtask

  // Expected strobes for one bit period of length p starting at cycle t.
  task automatic exp_period(input int t, input int p, input int s, input int w);
    exp_q.push_back(ev(t + p - 1, 0, 0));
    if (60 < p) exp_q.push_back(ev(t + 60, 1, 0));
    exp_q.push_back(ev(t + s, 2, 0));
    exp_q.push_back(ev(t + s + w, 3, 0));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bif.enable = 1'b1;
    bif.resync = 1'b0;
    bif.baud_div = 16'd5208;
    bif.pulse_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      go();
      @(negedge clock);
      n_checks++;
      if ({bif.full_baud, bif.half_bit_sample, bif.pulse, bif.os_tick, bif.os_idx} !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %b, expected 00000000",
                 {bif.full_baud, bif.half_bit_sample, bif.pulse, bif.os_tick, bif.os_idx});
      end
    end
    go();
    reset = 1'b0;
    bif.enable = 1'b0;
  endtask

  task automatic test_mode0();
    start_run(P0, 1'b0);
    rec_os = 1'b1;
    exp_period(t0, P0, 2116, 976);
    exp_period(t0 + P0, P0, 2116, 976);
`ifdef IR_OS_TICK_EN
    for (int p = 0; p < 2; p++) begin
      for (int k = 1; k <= 16; k++) exp_q.push_back(ev(t0 + p * P0 + k * 325 - 1, 4, 0));
      for (int k = 1; k <= 15; k++) exp_q.push_back(ev(t0 + p * P0 + k * 325, 5, k));
    end
    exp_q.push_back(ev(t0 + P0, 5, 0));
`endif
    scan(2 * P0);
`ifdef IR_OS_TICK_EN
    rec_os = 1'b0;
`endif
    exp_q.sort();
    while (exp_q.size() > 0 || act_q.size() > 0) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      a = (act_q.size() > 0) ? act_q.pop_front() : -1;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL mode0_event: got cyc %0d kind %0d val %0d, expected cyc %0d kind %0d val %0d",
                 a / 128, (a % 128) / 16, a % 16, e / 128, (e % 128) / 16, e % 16);
      end
    end
  endtask

  task automatic test_mode1();
    start_run(P0, 1'b1);
    exp_period(t0, P0, 2563, 82);
    exp_period(t0 + P0, P0, 2116, 976);
    scan(3000);
    bif.pulse_mode = 1'b0;
    scan(2 * P0 - 3000);
    exp_q.sort();
    while (exp_q.size() > 0 || act_q.size() > 0) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      a = (act_q.size() > 0) ? act_q.pop_front() : -1;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL mode1_event: got cyc %0d kind %0d val %0d, expected cyc %0d kind %0d val %0d",
                 a / 128, (a % 128) / 16, a % 16, e / 128, (e % 128) / 16, e % 16);
      end
    end
  endtask

  task automatic test_baud_change();
    start_run(P0, 1'b0);
    exp_period(t0, P0, 2116, 976);
    exp_period(t0 + P0, 2604, 1058, 488);
    exp_period(t0 + P0 + 2604, 2604, 1058, 488);
    scan(1000);
    bif.baud_div = 16'd2604;
    scan(P0 - 1000 + 2 * 2604);
    exp_q.sort();
    while (exp_q.size() > 0 || act_q.size() > 0) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      a = (act_q.size() > 0) ? act_q.pop_front() : -1;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL baud_change_event: got cyc %0d kind %0d val %0d, expected cyc %0d kind %0d val %0d",
                 a / 128, (a % 128) / 16, a % 16, e / 128, (e % 128) / 16, e % 16);
      end
    end
  endtask

  task automatic test_resync();
    int t1, t2;
    start_run(P0, 1'b0);
    t1 = t0 + P0;
    t2 = t1 + 1001;
    exp_q.push_back(ev(t0 + 60, 1, 0));
    exp_q.push_back(ev(t0 + 2116, 2, 0));
    exp_q.push_back(ev(t0 + 3092, 3, 0));
    exp_q.push_back(ev(t1 + 60, 1, 0));
    exp_period(t2, P0, 2116, 976);
    scan(P0 - 1);
    go();
    bif.resync = 1'b1;
    scan(1);
    go();
    bif.resync = 1'b0;
    scan(1000);
    go();
    bif.resync = 1'b1;
    scan(1);
    go();
    bif.resync = 1'b0;
    scan(P0);
    exp_q.sort();
    while (exp_q.size() > 0 || act_q.size() > 0) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      a = (act_q.size() > 0) ? act_q.pop_front() : -1;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL resync_event: got cyc %0d kind %0d val %0d, expected cyc %0d kind %0d val %0d",
                 a / 128, (a % 128) / 16, a % 16, e / 128, (e % 128) / 16, e % 16);
      end
    end
  endtask

  task automatic test_enable_drop();
    int t1;
    start_run(P0, 1'b0);
    scan(2200);
    for (int i = 0; i < 3; i++) begin
      go();
      bif.enable = 1'b0;
      @(negedge clock);
      n_checks++;
      if ({bif.full_baud, bif.half_bit_sample, bif.pulse, bif.os_tick, bif.os_idx} !== 8'd0) begin
        n_fail++;
        $display("FAIL enable_drop_outputs: got %b, expected 00000000",
                 {bif.full_baud, bif.half_bit_sample, bif.pulse, bif.os_tick, bif.os_idx});
      end
    end
    go();
    bif.baud_div = 16'd5;
    bif.enable   = 1'b1;
    t1 = cyc;
    prev_pulse = 1'b0;
    exp_q.delete();
    act_q.delete();
    for (int k = 0; k < 3; k++) exp_period(t1 + 16 * k, 16, 7, 3);
    scan(48);
    exp_q.sort();
    while (exp_q.size() > 0 || act_q.size() > 0) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      a = (act_q.size() > 0) ? act_q.pop_front() : -1;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL min_period_event: got cyc %0d kind %0d val %0d, expected cyc %0d kind %0d val %0d",
                 a / 128, (a % 128) / 16, a % 16, e / 128, (e % 128) / 16, e % 16);
      end
    end
  endtask

  task automatic test_reset_mid();
    start_run(P0, 1'b0);
    scan(2200);
    for (int i = 0; i < 2; i++) begin
      go();
      reset = 1'b1;
      @(negedge clock);
      n_checks++;
      if ({bif.full_baud, bif.half_bit_sample, bif.pulse} !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_mid_outputs: got %b, expected 000",
                 {bif.full_baud, bif.half_bit_sample, bif.pulse});
      end
    end
    go();
    reset = 1'b0;
    t0 = cyc;
    prev_pulse = 1'b0;
    exp_q.delete();
    act_q.delete();
    exp_period(t0, P0, 2116, 976);
    scan(P0);
    exp_q.sort();
    while (exp_q.size() > 0 || act_q.size() > 0) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      a = (act_q.size() > 0) ? act_q.pop_front() : -1;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL reset_restart_event: got cyc %0d kind %0d val %0d, expected cyc %0d kind %0d val %0d",
                 a / 128, (a % 128) / 16, a % 16, e / 128, (e % 128) / 16, e % 16);
      end
    end
  endtask

  initial begin
`ifdef IR_OS_TICK_EN
    rec_os = 1'b0;
`else
    rec_os = 1'b1;
`endif
    bif.enable     = 1'b0;
    bif.resync     = 1'b0;
    bif.baud_div   = 16'd5208;
    bif.pulse_mode = 1'b0;
    test_reset();
    test_mode0();
    test_mode1();
    test_baud_change();
    test_resync();
    test_enable_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
